// File: rtl/uart_tx_if.sv
// Handshake/data bundle between the loader control logic and the UART transmitter.
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 ticks;
  logic                 tx_start;
  logic [DATA_BITS-1:0] din;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done_tick;

  modport master (output ticks, tx_start, din, input tx, tx_busy, tx_done_tick);
  modport slave  (input ticks, tx_start, din, output tx, tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter driven by a 16x oversampling tick: start, DATA_BITS data LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the last data bit.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic       clock,
  input  logic       reset,
  uart_tx_if.slave   bus
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [SW-1:0]        s, s_n;
  logic [NW-1:0]        n, n_n;
  logic [DATA_BITS-1:0] b, b_n;
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      tx_q   <= tx_n;
      done_q <= done_n;
`ifdef UART_TX_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: if (bus.tx_start) begin
        b_n     = bus.din;
        s_n     = '0;
        state_n = START;
`ifdef UART_TX_PARITY_EN
        par_n   = ^bus.din;
`endif
      end
      START: if (bus.ticks) begin
        if (s == SW'(15)) begin
          s_n     = '0;
          n_n     = '0;
          state_n = DATA;
        end else s_n = s + SW'(1);
      end
      DATA: if (bus.ticks) begin
        if (s == SW'(15)) begin
          s_n = '0;
          b_n = b >> 1;
          if (n == NW'(DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          else n_n = n + NW'(1);
        end else s_n = s + SW'(1);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bus.ticks) begin
        if (s == SW'(15)) begin
          s_n     = '0;
          state_n = STOP;
        end else s_n = s + SW'(1);
      end
`endif
      STOP: if (bus.ticks) begin
        if (s == SW'(SB_TICK - 1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else s_n = s + SW'(1);
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so tx is a clean flop output.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.tx           = tx_q;
  assign bus.tx_done_tick = done_q;
  assign bus.tx_busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: tick-count-based frame model, table vectors, corner sequences, random frames.
module tb_uart_tx;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          ticks_r  = 1'b0;
  logic          tx_start = 1'b0;
  logic          sel32    = 1'b0;
  logic          tick_en  = 1'b1;
  logic [DB-1:0] din      = '0;
  int            TP       = 13;
  int            n_pass   = 0;
  int            n_tot    = 0;

  uart_tx_if #(.DATA_BITS(DB)) bus ();
  uart_tx_if #(.DATA_BITS(DB)) bus32 ();

  uart_tx #(.DATA_BITS(DB), .SB_TICK(16)) u_dut   (.clock(clock), .reset(reset), .bus(bus));
  uart_tx #(.DATA_BITS(DB), .SB_TICK(32)) u_dut32 (.clock(clock), .reset(reset), .bus(bus32));

  assign bus.ticks      = ticks_r;
  assign bus.din        = din;
  assign bus.tx_start   = tx_start & ~sel32;
  assign bus32.ticks    = ticks_r;
  assign bus32.din      = din;
  assign bus32.tx_start = tx_start & sel32;

  wire m_tx   = sel32 ? bus32.tx           : bus.tx;
  wire m_busy = sel32 ? bus32.tx_busy      : bus.tx_busy;
  wire m_done = sel32 ? bus32.tx_done_tick : bus.tx_done_tick;

  // Tick strobe every TP clocks, changed on the falling edge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (cnt >= TP - 1) cnt = 0; else cnt++;
      ticks_r = tick_en && (cnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic start_frame(input logic [7:0] d, input bit hold);
    tx_start = 1'b1;
    din      = d;
    @(posedge clock);
    #1;
    if (!hold) tx_start = 1'b0;
  endtask

  // Monitors one frame from its acceptance edge. Bit k occupies ticks 16k+1..16k+16
  // after acceptance, so it is sampled right after tick 16k+8.
  task automatic check_frame(input logic [7:0] d, input logic exp_par,
                             input int poke_at, input int freeze_at, input int abort_at);
    logic fb [0:15];
    int   sb, nt, tcnt, clk, budget;
    bit   fin, busy_ok, tk, ok;
    logic v;
    sb = sel32 ? 32 : 16;
    nt = 16 * (1 + DB + P) + sb;
    for (int i = 0; i < 16; i++) fb[i] = 1'b1;
    fb[0] = 1'b0;
    for (int i = 0; i < DB; i++) fb[1 + i] = d[i];
    if (P == 1) fb[1 + DB] = exp_par;
    tcnt = 0; clk = 0; fin = 0; busy_ok = 1;
    budget = nt * TP + 800;
    while (!fin && clk < budget) begin
      @(posedge clock);
      tk = ticks_r;
      clk++;
      if (tk) tcnt++;
      #1;
      if (tk && (tcnt % 16) == 8) chk($sformatf("bit%0d", tcnt / 16), m_tx, fb[tcnt / 16]);
      if (m_done) begin
        chk("done_tick_time", tcnt, nt);
        if (freeze_at == 0)
          chk("frame_clocks", (clk > (nt - 1) * TP) && (clk <= nt * TP), 1);
        chk("busy_during_frame", busy_ok, 1);
        fin = 1;
      end else if (!m_busy) busy_ok = 0;
      if (poke_at > 0 && tk && tcnt == poke_at) begin tx_start = 1'b1; din = ~d; end
      if (poke_at > 0 && tk && tcnt == poke_at + 4) begin tx_start = 1'b0; din = d; end
      if (freeze_at > 0 && tk && tcnt == freeze_at) begin
        tick_en = 1'b0;
        v  = m_tx;
        ok = 1;
        repeat (500) begin
          @(posedge clock); #1;
          if (m_tx !== v || !m_busy || m_done) ok = 0;
        end
        chk("freeze_holds", ok, 1);
        tick_en = 1'b1;
      end
      if (abort_at > 0 && tk && tcnt == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_tx_async", m_tx, 1);
        chk("abort_busy_async", m_busy, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        ok = 1;
        repeat (300) begin
          @(posedge clock); #1;
          if (m_done || m_busy) ok = 0;
        end
        chk("abort_no_done", ok, 1);
        return;
      end
    end
    chk("frame_completed", fin, 1);
  endtask

  task automatic after_frame();
    @(posedge clock); #1;
    chk("done_one_clock", m_done, 0);
    chk("idle_after_frame", m_busy, 0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [7:0] d;
    bit         ok;
    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0};
    vecs[2] = '{8'hA2, 1'b1};
    vecs[3] = '{8'h0F, 1'b0};
    vecs[4] = '{8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h80, 1'b1};
    vecs[7] = '{8'h01, 1'b1};

    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx",     bus.tx, 1);
    chk("rst_busy",   bus.tx_busy, 0);
    chk("rst_done",   bus.tx_done_tick, 0);
    chk("rst_tx32",   bus32.tx, 1);
    chk("rst_busy32", bus32.tx_busy, 0);
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("idle_tx", bus.tx, 1);

    foreach (vecs[i]) begin
      start_frame(vecs[i].din, 0);
      check_frame(vecs[i].din, vecs[i].par, 0, 0, 0);
      after_frame();
    end

    // tx_start with different din during DATA must not disturb the frame.
    start_frame(8'h00, 0);
    check_frame(8'h00, 1'b0, 40, 0, 0);
    ok = 1;
    repeat (50) begin
      @(posedge clock); #1;
      if (m_busy) ok = 0;
    end
    chk("no_second_frame", ok, 1);

    // tx_start held high: exactly one IDLE clock between frames.
    start_frame(8'hA5, 1);
    check_frame(8'hA5, 1'b0, 0, 0, 0);
    chk("gap_idle_busy", m_busy, 0);
    @(posedge clock); #1;
    chk("restart_busy", m_busy, 1);
    chk("restart_tx", m_tx, 0);
    tx_start = 1'b0;
    check_frame(8'hA5, 1'b0, 0, 0, 0);
    after_frame();

    // Reset during data bit 3, then a clean frame.
    start_frame(8'h3C, 0);
    check_frame(8'h3C, 1'b0, 0, 0, 16 * 4 + 5);
    start_frame(8'h0F, 0);
    check_frame(8'h0F, 1'b0, 0, 0, 0);
    after_frame();

    // Ticks stopped for 500 clocks mid-DATA.
    start_frame(8'hC6, 0);
    check_frame(8'hC6, 1'b0, 0, 16 * 3 + 4, 0);
    after_frame();

    // Two stop bits on the SB_TICK=32 instance.
    sel32 = 1'b1;
    start_frame(8'h5A, 0);
    check_frame(8'h5A, 1'b0, 0, 0, 0);
    after_frame();
    sel32 = 1'b0;

    for (int k = 0; k < 20; k++) begin
      TP = $urandom_range(1, 20);
      d  = 8'($urandom);
      repeat ($urandom_range(0, 7)) @(posedge clock);
      #1;
      start_frame(d, 0);
      check_frame(d, ^d, 0, 0, 0);
      after_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter that consumes the 16x oversampling `ticks` strobe produced by the baud-rate generator.
- Serialises one parallel byte per request as a frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit, stop bit(s) (1).
- Sits between the debug/loader control logic that issues `tx_start` and the board TX pin.

Parameters:
- DATA_BITS, 8, number of data bits per frame (valid range 5..8).
- SB_TICK, 16, number of ticks the stop bit lasts (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- ticks  input  1  one-clock 16x-baud strobe from the baud-rate generator.
- tx_start  input  1  request to send `din`; sampled every clock.
- din  input  DATA_BITS  byte to transmit; captured in the same cycle `tx_start` is accepted.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  1 while a frame is in progress (any state other than IDLE).
- tx_done_tick  output  1  one-clock pulse when the stop bit completes.

Behaviour:
- Reset (reset=0): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, tick counter=0, bit counter=0, shift register=0.
- Registers: state (IDLE, START, DATA, PARITY, STOP); tick counter s (enough bits for SB_TICK-1); bit counter n ($clog2(DATA_BITS) bits); shift register b (DATA_BITS); tx registered (no glitches).
- IDLE:
  - tx=1.
  - If tx_start=1: b<=din, s<=0, state<=START. Acceptance does not wait for `ticks`.
- START:
  - tx=0.
  - On each ticks=1: if s==15, then s<=0, n<=0, state<=DATA; else s<=s+1.
- DATA:
  - tx=b[0].
  - On each ticks=1: if s==15, then s<=0, b<=b>>1, and if n==DATA_BITS-1 go to PARITY (macro defined) or STOP; otherwise n<=n+1. Else s<=s+1.
- PARITY (present only with the macro):
  - tx=parity bit.
  - Leaves after 16 ticks to STOP, s<=0.
- STOP:
  - tx=1.
  - On ticks=1 with s==SB_TICK-1: state<=IDLE, tx_done_tick<=1 for exactly one clock. Else s<=s+1.
- Bit timing:
  - Each bit lasts exactly 16 ticks; stop lasts SB_TICK ticks.
  - The start bit may be up to one tick period short of 16 ticks, because acceptance is not tick-aligned. It is never longer.
- tx_start outside IDLE is ignored; `din` is not re-captured.
  - This includes the cycle in which tx_done_tick is asserted (state is still STOP at that edge).
  - tx_start held high continuously yields back-to-back frames, with one IDLE clock between them.
- ticks=0 freezes all counters; the line holds its current value indefinitely.
- Reset asserted mid-frame: immediate return to reset state, tx=1 asynchronously. No tx_done_tick is emitted for the aborted frame.
- tx_busy is combinational from state (state!=IDLE).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds the PARITY state after the last data bit.
  - Parity bit = XOR of all captured data bits (even parity), computed from `din` at acceptance and stored in a 1-bit register.
  - Frame length = 1+DATA_BITS+1 bits plus the stop bit(s).
- Undefined:
  - The PARITY state and parity register do not exist.
  - DATA goes directly to STOP.

Test Plan:
- Byte 0x55, ticks every 13 clocks, SB_TICK=16, macro off: tx_start pulse -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 208 clocks (start bit 196..208). tx_done_tick pulses once ~2080 clocks after start; tx_busy high throughout.
- Byte 0xA3 with UART_TX_PARITY_EN -> data bits 1,1,0,0,0,1,0,1, then parity bit 0 (four ones), then stop bit. Repeat with 0xA2 -> parity 1.
- tx_start re-asserted with din=0xFF during DATA of a 0x00 frame -> frame carries 0x00 unchanged, no second frame. tx_start held through the tx_done_tick cycle -> next frame starts exactly one clock later.
- Reset driven low during bit 3 of a frame -> tx=1 and tx_busy=0 in the same cycle (asynchronous), no tx_done_tick. After release, a new 0x0F frame transmits correctly.
- ticks held at 0 for 500 clocks mid-DATA -> tx constant, no state change. Frame resumes and completes with correct bits once ticks restart.
- SB_TICK=32 -> stop bit lasts 32 ticks (416 clocks at 13 clocks/tick) before tx_done_tick.
